// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and the write-port priority resolver for regfile_mp.
`default_nettype none

package regfile_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;
  localparam int REG_ZERO       = 0;
  localparam int MAX_WR         = 32;

  // Returns the highest-index set bit of a per-port hit vector; 0 when empty.
  function automatic int win_port(input logic [MAX_WR-1:0] hits);
    int w;
    w = 0;
    for (int j = 0; j < MAX_WR; j++) begin
      if (hits[j]) w = j;
    end
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port with zero-register masking.
// Write-first bypass over all write ports when REGFILE_BYPASS_EN is defined.
`default_nettype none

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
`ifdef REGFILE_BYPASS_EN
  ,
  parameter int NUM_WR = 2
`endif
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        rd_addr_i,
  input  logic [DATA_W-1:0]        entry_i,
  input  logic                     busy_i,
`ifdef REGFILE_BYPASS_EN
  input  logic [NUM_WR-1:0]        wr_en_i,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0] wr_data_i,
`endif
  output logic [DATA_W-1:0]        rd_data_o,
  output logic                     rd_busy_o
);

  logic [DATA_W-1:0] rd_data_d, rd_data_q;
  logic              rd_busy_d, rd_busy_q;
`ifdef REGFILE_BYPASS_EN
  logic [MAX_WR-1:0] hits;
`endif

  always_comb begin
    rd_data_d = entry_i;
    rd_busy_d = busy_i;
`ifdef REGFILE_BYPASS_EN
    hits = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      hits[j] = wr_en_i[j] && (wr_addr_i[j*ADDR_W +: ADDR_W] == rd_addr_i);
    end
    if (|hits) rd_data_d = wr_data_i[win_port(hits)*DATA_W +: DATA_W];
`endif
    if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
      rd_data_d = '0;
      rd_busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
      rd_busy_q <= 1'b0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_data_o = rd_data_q;
  assign rd_busy_o = rd_busy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with hardwired zero register and busy scoreboard.
// Define REGFILE_BYPASS_EN for write-first reads; default is read-first.
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] entry_q [DEPTH];
  logic [DATA_W-1:0] entry_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [MAX_WR-1:0] hits;

  // Alloc is applied after the write clear so a same-edge issue keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    hits   = '0;
    for (int a = 0; a < DEPTH; a++) entry_d[a] = entry_q[a];
    for (int a = 1; a < DEPTH; a++) begin
      hits = '0;
      for (int j = 0; j < NUM_WR; j++) begin
        hits[j] = wr_en[j] && (wr_addr[j*ADDR_W +: ADDR_W] == ADDR_W'(a));
      end
      if (|hits) begin
        entry_d[a] = wr_data[win_port(hits)*DATA_W +: DATA_W];
        busy_d[a]  = 1'b0;
      end
      if (alloc_en && (alloc_addr == ADDR_W'(a))) busy_d[a] = 1'b1;
    end
    entry_d[REG_ZERO] = '0;
    busy_d[REG_ZERO]  = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q <= '{default: '0};
      busy_q  <= '0;
    end else begin
      entry_q <= entry_d;
      busy_q  <= busy_d;
    end
  end

  assign busy_vec = busy_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    assign addr = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
`ifdef REGFILE_BYPASS_EN
      ,
      .NUM_WR (NUM_WR)
`endif
    ) u_port (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_i (addr),
      .entry_i   (entry_q[addr]),
`ifdef REGFILE_BYPASS_EN
      .busy_i    (busy_d[addr]),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
`else
      .busy_i    (busy_q[addr]),
`endif
      .rd_data_o (rd_data[i*DATA_W +: DATA_W]),
      .rd_busy_o (rd_busy[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized and directed checks of regfile_mp against an array-based model.
`default_nettype none

module tb_regfile_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic [NW-1:0]    wr_en;
  logic [NW*AW-1:0] wr_addr;
  logic [NW*DW-1:0] wr_data;
  logic             alloc_en;
  logic [AW-1:0]    alloc_addr;
  logic [DEPTH-1:0] busy_vec;

  regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_vec   (busy_vec)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  logic [NR*DW-1:0] m_rd_data;
  logic [NR-1:0]    m_rd_busy;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_mem[k]) m_mem[k] = '0;
    m_busy    = '0;
    m_rd_data = '0;
    m_rd_busy = '0;
  endtask

  // Apply one rising edge to the model: later ports overwrite earlier ones,
  // writes clear busy, then an alloc sets it.
  task automatic model_edge();
    logic [DW-1:0]    nm [DEPTH];
    logic [DEPTH-1:0] nb;
    int a;
    nm = m_mem;
    nb = m_busy;
    for (int j = 0; j < NW; j++) begin
      if (wr_en[j]) begin
        a = int'(wr_addr[j*AW +: AW]);
        if (a != 0) begin
          nm[a] = wr_data[j*DW +: DW];
          nb[a] = 1'b0;
        end
      end
    end
    if (alloc_en && alloc_addr != 0) nb[alloc_addr] = 1'b1;
    for (int i = 0; i < NR; i++) begin
      a = int'(rd_addr[i*AW +: AW]);
`ifdef REGFILE_BYPASS_EN
      m_rd_data[i*DW +: DW] = nm[a];
      m_rd_busy[i]          = nb[a];
`else
      m_rd_data[i*DW +: DW] = m_mem[a];
      m_rd_busy[i]          = m_busy[a];
`endif
    end
    m_mem  = nm;
    m_busy = nb;
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    rd_addr    = '0;
    alloc_en   = 1'b0;
    alloc_addr = '0;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    wr_en[p]              = 1'b1;
    wr_addr[p*AW +: AW]   = AW'(a);
    wr_data[p*DW +: DW]   = d;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic alloc(input int a);
    alloc_en   = 1'b1;
    alloc_addr = AW'(a);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rd_data", rd_data, m_rd_data);
      chk("rd_busy", rd_busy, m_rd_busy);
      chk("busy_vec", busy_vec, m_busy);
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rd_data", rd_data, 0);
    chk("reset_rd_busy", rd_busy, 0);
    chk("reset_busy_vec", busy_vec, 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    idle(); wr(0, 20, 50); step();
    idle(); rd(1, 20); step();
    chk("wr20_rd_port1", rd_data[63:32], 50);

    idle(); wr(0, 0, 32'hFFFF); step();
    idle(); rd(0, 0); step();
    chk("reg0_reads_zero", rd_data[31:0], 0);

    idle(); wr(0, 7, 32'h11); wr(1, 7, 32'h22); step();
    idle(); rd(0, 7); step();
    chk("write_priority", rd_data[31:0], 32'h22);

    idle(); wr(0, 9, 32'h1); step();
    idle(); rd(0, 9); wr(1, 9, 32'hABCD); step();
`ifdef REGFILE_BYPASS_EN
    chk("same_edge_rw", rd_data[31:0], 32'hABCD);
`else
    chk("same_edge_rw", rd_data[31:0], 32'h1);
`endif
    idle(); rd(0, 9); step();
    chk("after_write_rd", rd_data[31:0], 32'hABCD);

    idle(); alloc(3); step();
    chk("alloc3_busy", busy_vec[3], 1);
    idle(); rd(1, 3); step();
    chk("alloc3_rd_busy", rd_busy[1], 1);
    idle(); wr(0, 3, 32'h5); step();
    chk("write3_clears", busy_vec[3], 0);
    idle(); alloc(3); wr(1, 3, 32'h6); step();
    chk("alloc_write_collide", busy_vec[3], 1);
    idle(); alloc(0); step();
    chk("alloc0_ignored", busy_vec[0], 0);

    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        idle();
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_reset_rd_data", rd_data, 0);
        chk("mid_reset_rd_busy", rd_busy, 0);
        chk("mid_reset_busy_vec", busy_vec, 0);
        step();
        step();
        rst_n = 1'b1;
        idle(); rd(0, 5); step();
        chk("rd5_after_reset", rd_data[31:0], 0);
      end else begin
        wr_en      = NW'($urandom_range(0, 3));
        alloc_en   = 1'($urandom_range(0, 1));
        alloc_addr = AW'($urandom_range(0, (c % 4 == 0) ? 31 : 7));
        for (int j = 0; j < NW; j++) begin
          wr_addr[j*AW +: AW] = AW'($urandom_range(0, (c % 4 == 0) ? 31 : 7));
          wr_data[j*DW +: DW] = $urandom;
        end
        for (int i = 0; i < NR; i++) begin
          rd_addr[i*AW +: AW] = AW'($urandom_range(0, (c % 4 == 0) ? 31 : 7));
        end
        step();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file for the pipelined MIPS datapath, generalising the 32x32 two-read/one-write file. It provides NUM_RD registered read ports, NUM_WR write ports with fixed priority, a hardwired-zero register 0, and a per-register busy scoreboard that is set at issue and cleared at writeback. The decode stage uses the busy bits for hazard detection; writeback drives the write ports.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports
- NUM_WR, 2, number of write ports
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i uses slice i
- rd_data  out  NUM_RD*DATA_W  registered read data
- rd_busy  out  NUM_RD  registered busy bit of the addressed register
- wr_en  in  NUM_WR  write strobes
- wr_addr  in  NUM_WR*ADDR_W  write addresses
- wr_data  in  NUM_WR*DATA_W  write data
- alloc_en  in  1  mark alloc_addr busy (instruction issue)
- alloc_addr  in  ADDR_W  register to mark busy
- busy_vec  out  2**ADDR_W  current scoreboard; bit 0 is constant 0

## Operation
- Storage: 2**ADDR_W entries of DATA_W bits. Entry 0 is never written and always reads 0.
- Write: on a rising edge with wr_en[j]=1 and wr_addr[j]!=0, entry wr_addr[j] <= wr_data[j]. Writes to address 0 are dropped.
- Write conflict: if several enabled ports target the same address, the highest-index port wins.
- Read: on each rising edge, rd_data[i] <= value of entry rd_addr[i], and rd_busy[i] <= busy[rd_addr[i]]. If rd_addr[i]=0, the port returns data 0 and busy 0.
- Scoreboard set: alloc_en=1 with alloc_addr!=0 sets busy[alloc_addr].
- Scoreboard clear: any enabled write to address a clears busy[a].
- Scoreboard collision: an alloc and a write to the same address in the same cycle leave busy=1 (alloc wins, because the new producer is pending).
- Reset: asynchronous assertion clears all entries, busy_vec, rd_data and rd_busy to 0, mid-operation included. The first edge after deassertion operates normally.

## Timing
- Read latency is 1 cycle: rd_addr sampled at edge N appears on rd_data after edge N.
- Write latency is 1 cycle: data written at edge N is visible to a read sampled at edge N+1 in all configurations.
- Read and write to the same address at the same edge are governed by REGFILE_BYPASS_EN (see Configuration).
- busy_vec reflects the state after the last edge. rd_busy for same-edge write/alloc follows the same bypass rule as the data.
- No stalls and no handshake; every port accepts on every cycle.

## Configuration
- REGFILE_BYPASS_EN defined: write-first behaviour.
  - A read at the same edge as a write to the same nonzero address returns the new data, using the winning write port.
  - rd_busy returns the post-edge busy value.
- REGFILE_BYPASS_EN undefined: read-first behaviour.
  - A same-edge read returns the old entry value and the old busy bit.
  - The datapath must then forward externally.

## Structure
- Package regfile_pkg holds:
  - default width constants (DATA_W, ADDR_W);
  - the REG_ZERO address constant;
  - a function that resolves the winning write port for a given address (highest index wins).
- Sub-module regfile_read_port is instantiated NUM_RD times. It handles:
  - the zero-address check;
  - the optional bypass mux over all write ports;
  - the output registers with async reset.
- Top level owns the storage array, the write-priority logic and the scoreboard.

## Test plan
- Reset with random traffic, assert rst_n=0 mid-stream:
  - rd_data, rd_busy and busy_vec go to 0 immediately;
  - a read of reg 5 after release returns 0.
- Write reg 20 = 50 on port 0, then read reg 20 on port 1 the next cycle -> rd_data[1]=50. A write of 0xFFFF to reg 0, then a read of reg 0 -> 0.
- Port 0 writes reg 7 = 0x11 and port 1 writes reg 7 = 0x22 at the same edge -> a later read returns 0x22.
- Read reg 9 at the same edge as a write of 0xABCD to reg 9 (old value 0x1):
  - with REGFILE_BYPASS_EN -> 0xABCD;
  - without it -> 0x1.
- Scoreboard sequence:
  - alloc reg 3 -> busy_vec[3]=1 and rd_busy=1 on a read of reg 3;
  - write reg 3 -> busy_vec[3]=0;
  - alloc and write reg 3 at the same edge -> busy_vec[3]=1;
  - alloc reg 0 -> busy_vec[0] stays 0.
